execute_stage: RTL and testbench

Execute stage of the 5-stage RV64 pipeline. It sits directly downstream of the ID/EX register and consumes its outputs, applying forwarding selects from the forwarding unit. It performs ALU operations, branch resolution and an iterative multiply/divide. While a multi-cycle op is in progress it stalls IF/ID and ID/EX; its results feed the EX/MEM register.

---
 rtl/core_pkg.sv | 52 +++++
 rtl/execute_stage_if.sv | 42 ++++
 rtl/execute_stage_muldiv_iter.sv | 124 ++++++++++++
 rtl/execute_stage.sv | 107 ++++++++++
 tb/tb_execute_stage.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared encodings for the RV64 execute stage: ALU/branch/mul-div codes,
// forwarding selects and the iterative mul/div state type.
package core_pkg;

  localparam int XLEN = 64;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;
  localparam logic [1:0] ALUOP_RSV = 2'b11;

  localparam logic [3:0] F4_ADD  = 4'b0000;
  localparam logic [3:0] F4_SUB  = 4'b1000;
  localparam logic [3:0] F4_AND  = 4'b0111;
  localparam logic [3:0] F4_OR   = 4'b0110;
  localparam logic [3:0] F4_XOR  = 4'b0100;
  localparam logic [3:0] F4_SLL  = 4'b0001;
  localparam logic [3:0] F4_SRL  = 4'b0101;
  localparam logic [3:0] F4_SRA  = 4'b1101;
  localparam logic [3:0] F4_SLT  = 4'b0010;
  localparam logic [3:0] F4_SLTU = 4'b0011;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [2:0] MD_MUL   = 3'b000;
  localparam logic [2:0] MD_MULHU = 3'b011;
  localparam logic [2:0] MD_DIV   = 3'b100;
  localparam logic [2:0] MD_DIVU  = 3'b101;
  localparam logic [2:0] MD_REM   = 3'b110;
  localparam logic [2:0] MD_REMU  = 3'b111;

  localparam logic [1:0] FWD_IDEX  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } ex_state_t;

  function automatic logic md_code_ok(input logic [2:0] f3);
    return (f3 == MD_MUL) || (f3 == MD_MULHU) || f3[2];
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle: operands, controls, forwarding
// and the execute results/stall fed back to the pipeline.
interface execute_stage_if;
  import core_pkg::*;

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] readdata1;
  logic [XLEN-1:0] readdata2;
  logic [XLEN-1:0] imm_data;
  logic [3:0]      funct4;
  logic [1:0]      aluop;
  logic            alusrc;
  logic            branch;
  logic            muldiv;
  logic [1:0]      forward_a;
  logic [1:0]      forward_b;
  logic [XLEN-1:0] ex_mem_result;
  logic [XLEN-1:0] mem_wb_result;
  logic [XLEN-1:0] result;
  logic            zero;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] branch_target;
  logic            branch_taken;
  logic            stall;

  modport master (
    output a, readdata1, readdata2, imm_data, funct4, aluop,
    output alusrc, branch, muldiv, forward_a, forward_b,
    output ex_mem_result, mem_wb_result,
    input  result, zero, store_data, branch_target,
    input  branch_taken, stall
  );

  modport slave (
    input  a, readdata1, readdata2, imm_data, funct4, aluop,
    input  alusrc, branch, muldiv, forward_a, forward_b,
    input  ex_mem_result, mem_wb_result,
    output result, zero, store_data, branch_target,
    output branch_taken, stall
  );

endinterface

// File: rtl/execute_stage_muldiv_iter.sv
// Iterative RV64 mul/div: 64-step shift-add multiply and restoring
// divide on magnitudes, signs applied when the result is presented.
module muldiv_iter
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  ex_state_t       state_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] dvs_q;
  logic [5:0]      cnt_q;
  logic [2:0]      op_q;
  logic            negq_q;
  logic            negr_q;

  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div0;
  logic            ovf;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_rem;
  logic [XLEN:0]   div_diff;
  logic            qbit;

  assign is_signed = op[2] & ~op[0];
  assign a_neg     = is_signed & a[XLEN-1];
  assign b_neg     = is_signed & b[XLEN-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign div0      = (b == '0);
  assign ovf       = is_signed && (a == {1'b1, {(XLEN-1){1'b0}}})
                     && (b == '1);

  assign mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
  assign div_rem  = {acc_q, lo_q[XLEN-1]};
  assign div_diff = div_rem - {1'b0, dvs_q};
  assign qbit     = ~div_diff[XLEN];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          op_q   <= op;
          cnt_q  <= '0;
          negq_q <= 1'b0;
          negr_q <= 1'b0;
          if (!op[2]) begin
            state_q <= MUL;
            acc_q   <= '0;
            lo_q    <= a;
            dvs_q   <= b;
          end else if (div0) begin
            // Quotient all-ones, remainder is the raw dividend
            state_q <= DONE;
            lo_q    <= '1;
            acc_q   <= a;
          end else if (ovf) begin
            state_q <= DONE;
            lo_q    <= a;
            acc_q   <= '0;
          end else begin
            state_q <= DIV;
            acc_q   <= '0;
            lo_q    <= a_mag;
            dvs_q   <= b_mag;
            negq_q  <= a_neg ^ b_neg;
            negr_q  <= a_neg;
          end
        end
        MUL: begin
          acc_q <= mul_sum[XLEN:1];
          lo_q  <= {mul_sum[0], lo_q[XLEN-1:1]};
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd63) state_q <= DONE;
        end
        DIV: begin
          acc_q <= qbit ? div_diff[XLEN-1:0] : div_rem[XLEN-1:0];
          lo_q  <= {lo_q[XLEN-2:0], qbit};
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd63) state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = !reset &&
                (((state_q == IDLE) && start) ||
                 (state_q == MUL) || (state_q == DIV));
  assign done = (state_q == DONE);

  always_comb begin
    result = '0;
    if (done) begin
      if (!op_q[2])     result = op_q[1] ? acc_q : lo_q;
      else if (op_q[1]) result = negr_q ? -acc_q : acc_q;
      else              result = negq_q ? -lo_q : lo_q;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// RV64 execute stage: forwarding, ALU, branch resolve and optional
// iterative mul/div (enabled by defining EX_MULDIV_EN).
module execute_stage
  import core_pkg::*;
(
  input logic            clk,
  input logic            reset,
  execute_stage_if.slave ex
);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] res;
  logic [5:0]      shamt;
  logic            cond;

  always_comb begin
    unique case (ex.forward_a)
      FWD_EXMEM: op_a = ex.ex_mem_result;
      FWD_MEMWB: op_a = ex.mem_wb_result;
      default:   op_a = ex.readdata1;
    endcase
    unique case (ex.forward_b)
      FWD_EXMEM: fwd_b = ex.ex_mem_result;
      FWD_MEMWB: fwd_b = ex.mem_wb_result;
      default:   fwd_b = ex.readdata2;
    endcase
  end

  assign op_b  = ex.alusrc ? ex.imm_data : fwd_b;
  assign shamt = op_b[5:0];

  always_comb begin
    alu_res = '0;
    unique case (ex.aluop)
      ALUOP_ADD: alu_res = op_a + op_b;
      ALUOP_BR:  alu_res = op_a - op_b;
      ALUOP_FN: begin
        unique case (ex.funct4)
          F4_ADD:  alu_res = op_a + op_b;
          F4_SUB:  alu_res = op_a - op_b;
          F4_AND:  alu_res = op_a & op_b;
          F4_OR:   alu_res = op_a | op_b;
          F4_XOR:  alu_res = op_a ^ op_b;
          F4_SLL:  alu_res = op_a << shamt;
          F4_SRL:  alu_res = op_a >> shamt;
          F4_SRA:  alu_res = $signed(op_a) >>> shamt;
          F4_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
          F4_SLTU: alu_res = XLEN'(op_a < op_b);
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  // Branches always compare against forwarded rs2, never the immediate
  always_comb begin
    unique case (ex.funct4[2:0])
      BR_EQ:   cond = (op_a == fwd_b);
      BR_NE:   cond = (op_a != fwd_b);
      BR_LT:   cond = ($signed(op_a) < $signed(fwd_b));
      BR_GE:   cond = ($signed(op_a) >= $signed(fwd_b));
      BR_LTU:  cond = (op_a < fwd_b);
      BR_GEU:  cond = (op_a >= fwd_b);
      default: cond = 1'b0;
    endcase
  end

`ifdef EX_MULDIV_EN
  logic            md_sel;
  logic            md_busy;
  logic            md_done;
  logic [XLEN-1:0] md_res;

  assign md_sel = ex.muldiv && (ex.aluop == ALUOP_FN);

  muldiv_iter u_md (
    .clk    (clk),
    .reset  (reset),
    .start  (md_sel && md_code_ok(ex.funct4[2:0])),
    .op     (ex.funct4[2:0]),
    .a      (op_a),
    .b      (op_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_res)
  );

  assign res      = md_done ? md_res : (md_sel ? '0 : alu_res);
  assign ex.stall = md_busy;
`else
  logic unused_md;
  assign unused_md = ^{clk, reset, ex.muldiv};
  assign res       = alu_res;
  assign ex.stall  = 1'b0;
`endif

  assign ex.result        = res;
  assign ex.zero          = (res == '0);
  assign ex.store_data    = fwd_b;
  assign ex.branch_target = ex.a + ex.imm_data;
  assign ex.branch_taken  = ex.branch && cond;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU/branch/forwarding vector table
// plus multi-cycle mul/div, special-case divide and reset-abort sequences.
module tb_execute_stage;
  import core_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  execute_stage_if bus ();

  execute_stage dut (
    .clk   (clk),
    .reset (reset),
    .ex    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  aluop;
    logic [3:0]  f4;
    logic        src;
    logic        br;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm;
    logic [63:0] pc;
    logic [63:0] exm;
    logic [63:0] mwb;
    logic [63:0] res;
    logic [63:0] sd;
    logic [63:0] tgt;
    logic        tk;
  } vec_t;

  vec_t tv[$];
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] M1  = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] ao, input logic [3:0] f4,
                       input logic src, input logic br, input logic md,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input logic [63:0] rd1, input logic [63:0] rd2,
                       input logic [63:0] imm, input logic [63:0] pc,
                       input logic [63:0] exm, input logic [63:0] mwb);
    bus.aluop = ao;  bus.funct4 = f4;  bus.alusrc = src;
    bus.branch = br; bus.muldiv = md;
    bus.forward_a = fa; bus.forward_b = fb;
    bus.readdata1 = rd1; bus.readdata2 = rd2;
    bus.imm_data = imm;  bus.a = pc;
    bus.ex_mem_result = exm; bus.mem_wb_result = mwb;
  endtask

  function automatic vec_t mk(
    input logic [1:0] ao, input logic [3:0] f4, input logic src,
    input logic br, input logic [1:0] fa, input logic [1:0] fb,
    input logic [63:0] rd1, input logic [63:0] rd2,
    input logic [63:0] imm, input logic [63:0] pc,
    input logic [63:0] exm, input logic [63:0] mwb,
    input logic [63:0] res, input logic [63:0] sd,
    input logic [63:0] tgt, input logic tk);
    vec_t v;
    v.aluop = ao; v.f4 = f4; v.src = src; v.br = br;
    v.fa = fa; v.fb = fb; v.rd1 = rd1; v.rd2 = rd2;
    v.imm = imm; v.pc = pc; v.exm = exm; v.mwb = mwb;
    v.res = res; v.sd = sd; v.tgt = tgt; v.tk = tk;
    return v;
  endfunction

  task automatic run_md(input string nm, input logic [2:0] f3,
                        input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp, input int exp_st);
    int n;
    n = 0;
    @(posedge clk); #1;
    drive(2'b10, {1'b0, f3}, 0, 0, 1, 0, 0, x, y, 0, 0, 0, 0);
    @(negedge clk);
    while (bus.stall && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({nm, " stalls"}, 64'(n), 64'(exp_st));
    chk({nm, " result"}, bus.result, exp);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst stall", 64'(bus.stall), 0);
    chk("rst result", bus.result, 0);
    chk("rst zero", 64'(bus.zero), 1);
    chk("rst taken", 64'(bus.branch_taken), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    tv.push_back(mk(2'b10, 4'b0000, 0, 0, 2'b10, 2'b00, 99, 7, 0, 0, 5, 0,
                    12, 7, 0, 0));
    tv.push_back(mk(2'b10, 4'b1101, 1, 0, 0, 0, MIN, 0, 4, 0, 0, 0,
                    64'hF800_0000_0000_0000, 0, 4, 0));
    tv.push_back(mk(2'b01, 4'b0100, 0, 1, 0, 0, M1, 1, -64'sd8, 64'h100,
                    0, 0, -64'sd2, 1, 64'hF8, 1));
    tv.push_back(mk(2'b00, 4'b0000, 1, 0, 0, 0, 64'h10, 64'h55, -64'sd8, 0,
                    0, 0, 8, 64'h55, -64'sd8, 0));
    tv.push_back(mk(2'b11, 4'b0000, 0, 0, 0, 0, 5, 6, 0, 0, 0, 0,
                    0, 6, 0, 0));
    tv.push_back(mk(2'b10, 4'b1000, 0, 0, 2'b00, 2'b01, 5, 9, 0, 0, 0, 5,
                    0, 5, 0, 0));
    tv.push_back(mk(2'b10, 4'b0111, 0, 0, 0, 0, 64'hF0, 64'h3C, 0, 0, 0, 0,
                    64'h30, 64'h3C, 0, 0));
    tv.push_back(mk(2'b10, 4'b0110, 0, 0, 0, 0, 64'hF0, 64'h0F, 0, 0, 0, 0,
                    64'hFF, 64'h0F, 0, 0));
    tv.push_back(mk(2'b10, 4'b0100, 0, 0, 0, 0, 64'hFF, 64'h0F, 0, 0, 0, 0,
                    64'hF0, 64'h0F, 0, 0));
    tv.push_back(mk(2'b10, 4'b0001, 1, 0, 0, 0, 1, 0, 64'h43, 0, 0, 0,
                    8, 0, 64'h43, 0));
    tv.push_back(mk(2'b10, 4'b0101, 0, 0, 0, 0, MIN, 63, 0, 0, 0, 0,
                    1, 63, 0, 0));
    tv.push_back(mk(2'b10, 4'b0010, 0, 0, 0, 0, M1, 1, 0, 0, 0, 0,
                    1, 1, 0, 0));
    tv.push_back(mk(2'b10, 4'b0011, 0, 0, 0, 0, M1, 1, 0, 0, 0, 0,
                    0, 1, 0, 0));
    tv.push_back(mk(2'b10, 4'b1111, 0, 0, 0, 0, 3, 4, 0, 0, 0, 0,
                    0, 4, 0, 0));
    tv.push_back(mk(2'b01, 4'b0000, 1, 1, 0, 0, 5, 5, 100, 64'h200, 0, 0,
                    64'hFFFF_FFFF_FFFF_FFA1, 5, 64'h264, 1));
    tv.push_back(mk(2'b01, 4'b0101, 0, 1, 0, 0, M1, 1, 0, 0, 0, 0,
                    -64'sd2, 1, 0, 0));
    tv.push_back(mk(2'b01, 4'b0110, 0, 1, 0, 2'b10, 1, 0, 0, 0, M1, 0,
                    2, M1, 0, 1));
    tv.push_back(mk(2'b01, 4'b0001, 0, 1, 0, 0, 3, 4, 0, 0, 0, 0,
                    M1, 4, 0, 1));
    tv.push_back(mk(2'b01, 4'b0010, 0, 1, 0, 0, 3, 3, 0, 0, 0, 0,
                    0, 3, 0, 0));
    tv.push_back(mk(2'b00, 4'b0000, 0, 0, 2'b11, 0, 3, 4, 0, 0, 100, 0,
                    7, 4, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tv[i]) begin
      @(posedge clk); #1;
      drive(tv[i].aluop, tv[i].f4, tv[i].src, tv[i].br, 0, tv[i].fa,
            tv[i].fb, tv[i].rd1, tv[i].rd2, tv[i].imm, tv[i].pc,
            tv[i].exm, tv[i].mwb);
      @(negedge clk);
      chk($sformatf("v%0d result", i), bus.result, tv[i].res);
      chk($sformatf("v%0d zero", i), 64'(bus.zero), 64'(tv[i].res == 0));
      chk($sformatf("v%0d store", i), bus.store_data, tv[i].sd);
      chk($sformatf("v%0d target", i), bus.branch_target, tv[i].tgt);
      chk($sformatf("v%0d taken", i), 64'(bus.branch_taken), 64'(tv[i].tk));
      chk($sformatf("v%0d stall", i), 64'(bus.stall), 0);
    end

`ifdef EX_MULDIV_EN
    run_md("mul", 3'b000, 7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mul after stall", 64'(bus.stall), 0);
    chk("mul after result", bus.result, 0);
    run_md("mulhu", 3'b011, M1, 2, 1, 65);
    run_md("div", 3'b100, -64'sd20, 3, -64'sd6, 65);
    run_md("rem", 3'b110, -64'sd20, 3, -64'sd2, 65);
    run_md("divu", 3'b101, 100, 7, 14, 65);
    run_md("remu", 3'b111, 100, 7, 2, 65);
    run_md("div0", 3'b100, 10, 0, M1, 1);
    run_md("remu0", 3'b111, 5, 0, 5, 1);
    run_md("removf", 3'b110, MIN, M1, 0, 1);
    run_md("divovf", 3'b100, MIN, M1, MIN, 1);

    @(posedge clk); #1;
    drive(2'b10, 4'b0010, 0, 0, 1, 0, 0, 3, 4, 0, 0, 0, 0);
    @(negedge clk);
    chk("md bad stall", 64'(bus.stall), 0);
    chk("md bad result", bus.result, 0);

    @(posedge clk); #1;
    drive(2'b10, 4'b0101, 0, 0, 1, 0, 0, 1000, 7, 0, 0, 0, 0);
    repeat (19) @(posedge clk);
    @(negedge clk);
    chk("abort pre stall", 64'(bus.stall), 1);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("abort rst stall", 64'(bus.stall), 0);
    @(posedge clk); #1 reset = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 0, 0, 2, 3, 0, 0, 0, 0);
    @(negedge clk);
    chk("abort next stall", 64'(bus.stall), 0);
    chk("abort add result", bus.result, 5);
    repeat (70) @(posedge clk);
    @(negedge clk);
    chk("abort late result", bus.result, 5);
    chk("abort late stall", 64'(bus.stall), 0);
`else
    @(posedge clk); #1;
    drive(2'b10, 4'b0000, 0, 0, 1, 0, 0, 7, 3, 0, 0, 0, 0);
    @(negedge clk);
    chk("nomd stall", 64'(bus.stall), 0);
    chk("nomd result", bus.result, 10);
    @(posedge clk); #1;
    drive(2'b10, 4'b0100, 0, 0, 1, 0, 0, 64'hFF, 64'h0F, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("nomd xor stall", 64'(bus.stall), 0);
    chk("nomd xor result", bus.result, 64'hF0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
